// File: rtl/stopwatch_counter.sv
// Stopwatch time base: four BCD digits (MM:SS) counting up or down on a
// gated 1 Hz strobe, a one-cycle wrap indicator, and a 4-digit scan
// multiplexer that drives an active-low seven-segment digit enable.
module stopwatch_counter #(
   parameter int MIN_TENS_MAX = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       count_enable,
   input  logic       tick,
   input  logic       scan_tick,
   input  logic       clear,
   input  logic       up_down,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       terminal,
   output logic [3:0] digit_sel,
   output logic [3:0] bcd_out
);

   localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

   logic       step;
   logic       carry_so;
   logic       carry_st;
   logic       carry_mo;
   logic       wrap;
   logic [1:0] scan_idx;

   // A digit passes a carry/borrow when it sits at the end of its range for
   // the current direction. The up test uses >= so an out-of-range value can
   // never count past its ceiling.
   function automatic logic at_limit(input logic [3:0] d, input logic [3:0] top,
                                     input logic up);
      return up ? (d >= top) : (d == 4'd0);
   endfunction

   // Next value of one digit when it is allowed to move.
   function automatic logic [3:0] next_digit(input logic [3:0] d, input logic [3:0] top,
                                             input logic up);
      if (up)
         return (d >= top) ? 4'd0 : d + 4'd1;
      else
         return ((d == 4'd0) || (d > top)) ? top : d - 4'd1;
   endfunction

   // Step qualification and the ripple of carries/borrows across digits.
   always_comb begin
      step     = tick & count_enable;
      carry_so = at_limit(sec_ones, 4'd9, up_down);
      carry_st = carry_so & at_limit(sec_tens, 4'd5, up_down);
      carry_mo = carry_st & at_limit(min_ones, 4'd9, up_down);
      wrap     = carry_mo & at_limit(min_tens, MT_MAX, up_down);
   end

   // Time digits: clear beats a coincident step; all digits move on one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (clear) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
      end else if (step) begin
         sec_ones <= next_digit(sec_ones, 4'd9, up_down);
         if (carry_so) sec_tens <= next_digit(sec_tens, 4'd5, up_down);
         if (carry_st) min_ones <= next_digit(min_ones, 4'd9, up_down);
         if (carry_mo) min_tens <= next_digit(min_tens, MT_MAX, up_down);
      end
   end

   // Wrap flag is high only in the cycle the wrapped value first appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) terminal <= 1'b0;
      else       terminal <= step & wrap & ~clear;
   end

   // Scan index free-runs on scan_tick, unaffected by counting or clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          scan_idx <= 2'd0;
      else if (scan_tick) scan_idx <= scan_idx + 2'd1;
   end

   // Display decode from the registered index and digits.
   always_comb begin
      digit_sel = ~(4'b0001 << scan_idx);
      case (scan_idx)
         2'd0:    bcd_out = sec_ones;
         2'd1:    bcd_out = sec_tens;
         2'd2:    bcd_out = min_ones;
         default: bcd_out = min_tens;
      endcase
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: a table of single-cycle
// vectors with hand-derived results, then multi-cycle scenarios checked
// against a seconds-based reference model through an expectation queue.
module tb_stopwatch_counter;

   localparam int MTM    = 5;
   localparam int PERIOD = (MTM + 1) * 600;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       count_enable = 1'b0;
   logic       tick = 1'b0;
   logic       scan_tick = 1'b0;
   logic       clear = 1'b0;
   logic       up_down = 1'b1;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       terminal;
   logic [3:0] digit_sel, bcd_out;

   typedef struct {
      logic [15:0] dig;
      logic        term;
      logic [3:0]  sel;
      logic [3:0]  bcd;
   } exp_t;

   typedef struct {
      logic        ce, tk, sc, clr, ud;
      logic [15:0] dig;
      logic        term;
      logic [3:0]  sel;
      logic [3:0]  bcd;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[13];

   int vectors = 0;
   int miscompares = 0;
   int m_t = 0;
   int m_idx = 0;

   stopwatch_counter #(.MIN_TENS_MAX(MTM)) dut (
      .clk(clk), .reset(reset), .count_enable(count_enable), .tick(tick),
      .scan_tick(scan_tick), .clear(clear), .up_down(up_down),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .terminal(terminal), .digit_sel(digit_sel),
      .bcd_out(bcd_out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] dig_now();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".digits"}, dig_now(), 16'h0000);
      check({tag, ".terminal"}, 16'(terminal), 16'h0);
      check({tag, ".digit_sel"}, 16'(digit_sel), 16'h000E);
      check({tag, ".bcd_out"}, 16'(bcd_out), 16'h0);
   endtask

   // Drive one cycle of inputs, queue the expectation, compare after the edge.
   task automatic apply(input logic ce, tk, sc, clr, ud, input exp_t e, input string tag);
      exp_t got;
      @(negedge clk);
      count_enable = ce; tick = tk; scan_tick = sc; clear = clr; up_down = ud;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         vectors++; miscompares++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         got = exp_q.pop_front();
         check({tag, ".digits"}, dig_now(), got.dig);
         check({tag, ".terminal"}, 16'(terminal), 16'(got.term));
         check({tag, ".digit_sel"}, 16'(digit_sel), 16'(got.sel));
         check({tag, ".bcd_out"}, 16'(bcd_out), 16'(got.bcd));
      end
   endtask

   function automatic logic [15:0] to_bcd(input int t);
      return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
   endfunction

   // Reference model works in whole seconds, then splits into digits.
   task automatic model_cycle(input logic ce, tk, sc, clr, ud, input string tag);
      exp_t e;
      logic [15:0] d;
      e.term = 1'b0;
      if (clr) m_t = 0;
      else if (ce && tk) begin
         if (ud) begin m_t = (m_t + 1) % PERIOD; e.term = (m_t == 0); end
         else    begin m_t = (m_t + PERIOD - 1) % PERIOD; e.term = (m_t == PERIOD - 1); end
      end
      if (sc) m_idx = (m_idx + 1) % 4;
      d = to_bcd(m_t);
      e.dig = d;
      case (m_idx)
         0: begin e.sel = 4'b1110; e.bcd = d[3:0];   end
         1: begin e.sel = 4'b1101; e.bcd = d[7:4];   end
         2: begin e.sel = 4'b1011; e.bcd = d[11:8];  end
         default: begin e.sel = 4'b0111; e.bcd = d[15:12]; end
      endcase
      apply(ce, tk, sc, clr, ud, e, tag);
   endtask

   // Reset pulsed between edges while step/scan are requested.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b1; count_enable = 1'b1; tick = 1'b1; scan_tick = 1'b1; clear = 1'b0;
      #1;
      check_reset_vals({tag, ".async"});
      @(posedge clk);
      #1;
      check_reset_vals({tag, ".held"});
      @(negedge clk);
      reset = 1'b0; tick = 1'b0; scan_tick = 1'b0; count_enable = 1'b0;
      m_t = 0; m_idx = 0;
   endtask

   initial begin
      #1_000_000;
      miscompares++;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      exp_t e;
      // ce tk sc clr ud | digits term sel bcd
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1110, 4'h1};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1101, 4'h0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1101, 4'h0};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'b1011, 4'h0};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5959, 1'b1, 4'b0111, 4'h5};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5958, 1'b0, 4'b0111, 4'h5};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 4'b1110, 4'h0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h5959, 1'b1, 4'b1110, 4'h9};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 4'b1110, 4'h0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'b1110, 4'h0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1101, 4'h0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 4'b1011, 4'h0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 4'b1011, 4'h0};

      #2;
      check_reset_vals("por");
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         e.dig = tbl[i].dig; e.term = tbl[i].term; e.sel = tbl[i].sel; e.bcd = tbl[i].bcd;
         apply(tbl[i].ce, tbl[i].tk, tbl[i].sc, tbl[i].clr, tbl[i].ud, e,
               $sformatf("tbl%0d", i));
      end

      // 61 seconds up from reset, terminal checked low every cycle.
      do_reset("run");
      repeat (61) model_cycle(1, 1, 0, 0, 1, "run");
      check("run.final", dig_now(), 16'h0101);

      // Pause holds and does not replay ticks.
      do_reset("pause");
      repeat (7) model_cycle(1, 1, 0, 0, 1, "pause.pre");
      repeat (5) model_cycle(0, 1, 0, 0, 1, "pause.hold");
      check("pause.held", dig_now(), 16'h0007);
      model_cycle(1, 1, 0, 0, 1, "pause.resume");
      check("pause.final", dig_now(), 16'h0008);

      // Scan at 12:34, clear priority, then async reset mid-count.
      do_reset("scan");
      repeat (754) model_cycle(1, 1, 0, 0, 1, "to1234");
      repeat (5) model_cycle(0, 0, 1, 0, 1, "scan");
      check("scan.digits", dig_now(), 16'h1234);
      check("scan.digit_sel", 16'(digit_sel), 16'h000D);
      check("scan.bcd_out", 16'(bcd_out), 16'h0003);
      model_cycle(1, 1, 0, 1, 1, "clear_prio");
      check("clear_prio.digits", dig_now(), 16'h0000);
      check("clear_prio.terminal", 16'(terminal), 16'h0);
      repeat (3) model_cycle(1, 1, 0, 0, 1, "post_clear");
      model_cycle(0, 0, 1, 0, 1, "post_clear.scan");
      do_reset("midcount");

      // Full sweeps in both directions with random scan activity.
      repeat (PERIOD) model_cycle(1, 1, 1'($urandom_range(0, 1)), 0, 1, "sweep_up");
      repeat (PERIOD) model_cycle(1, 1, 1'($urandom_range(0, 1)), 0, 0, "sweep_dn");
      model_cycle(1, 0, 0, 0, 0, "sweep_end");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL have parameter MIN_TENS_MAX, default 5, which is the highest value of the minute-tens digit (legal range 1..9).
REQ-002 Port clk, input, 1 bit: the single system clock (crystal clock); all registers SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port count_enable, input, 1 bit: level input from the pause FSM; 1 means run, 0 means hold.
REQ-005 Port tick, input, 1 bit: one-clk-wide 1 Hz count strobe, already synchronous to clk.
REQ-006 Port scan_tick, input, 1 bit: one-clk-wide display scan strobe, synchronous to clk.
REQ-007 Port clear, input, 1 bit: synchronous clear, active-high, one-shot pulse.
REQ-008 Port up_down, input, 1 bit: 1 counts up, 0 counts down.
REQ-009 Ports min_tens, min_ones, sec_tens, sec_ones, output, 4 bits each: registered BCD time digits.
REQ-010 Port terminal, output, 1 bit: registered one-cycle wrap indicator.
REQ-011 Port digit_sel, output, 4 bits: active-low one-hot digit enable for the seven-segment display.
REQ-012 Port bcd_out, output, 4 bits: BCD value of the currently selected digit.

Function
REQ-013 The block SHALL generate an internal step when tick=1 and count_enable=1 in the same cycle; no other condition SHALL change the time digits except clear and reset.
REQ-014 In up mode, a step SHALL update the digits as follows:
- sec_ones increments 0..9; on 9 it wraps to 0 and carries.
- sec_tens increments 0..5; on 5 with carry-in it wraps to 0 and carries.
- min_ones increments 0..9; on 9 with carry-in it wraps to 0 and carries.
- min_tens increments 0..MIN_TENS_MAX; on MIN_TENS_MAX with carry-in it wraps to 0.
REQ-015 In down mode, a step SHALL update the digits as the mirror of REQ-014:
- Each digit decrements and borrows when it is 0.
- sec_ones reloads to 9, sec_tens to 5, min_ones to 9, and min_tens to MIN_TENS_MAX.
REQ-016 All digit updates caused by a step SHALL occur on the same clk edge; latency from the step cycle to new digit values SHALL be 1 clock.
REQ-017 terminal SHALL be 1 for exactly the one cycle in which the digits first show the wrapped value:
- Up mode: MIN_TENS_MAX9:59 -> 00:00.
- Down mode: 00:00 -> MIN_TENS_MAX9:59.
- terminal SHALL be 0 in every other cycle.
REQ-018 clear=1 SHALL set all digits to 0 on the next edge, with priority over a coincident step; terminal SHALL be 0 in the cycle following a clear.
REQ-019 A change of up_down SHALL take effect on the next step; there SHALL be no other side effect.
REQ-020 When count_enable=0, ticks SHALL be ignored and all digits SHALL hold; no tick SHALL be buffered or replayed when count_enable later rises.
REQ-021 A 2-bit scan index SHALL advance 0->1->2->3->0 on each scan_tick, independently of counting, clear and count_enable.
REQ-022 Output decode from the scan index:
- digit_sel SHALL equal ~(4'b0001 << index).
- bcd_out SHALL be sec_ones, sec_tens, min_ones or min_tens for index 0, 1, 2 or 3 respectively.
- Both outputs SHALL be decoded combinationally from the registered index and the digits.
REQ-023 Digit values outside the legal BCD range SHALL be unreachable from reset.

Reset
REQ-024 Assertion of reset SHALL immediately, without waiting for a clk edge, force the following:
- All digits to 0.
- terminal to 0.
- scan index to 0, so digit_sel=4'b1110 and bcd_out=0.
REQ-025 A reset asserted mid-count or mid-wrap SHALL take priority over clear, step and scan_tick; counting SHALL resume from 00:00 on the first step after reset deasserts.

Verification
REQ-026 Scenario, run: reset, then count_enable=1, up_down=1, 61 ticks -> digits 01:01, terminal never asserted.
REQ-027 Scenario, up wrap: counter reaches 59:59 (MIN_TENS_MAX=5), then one tick -> 00:00 and terminal=1 for exactly one cycle.
REQ-028 Scenario, down wrap: from 00:00, up_down=0, one tick -> 59:59 and terminal=1 for one cycle; a second tick -> 59:58 and terminal=0.
REQ-029 Scenario, pause: at 00:07, count_enable=0 and 5 ticks -> digits stay 00:07; count_enable=1 and 1 tick -> 00:08.
REQ-030 Scenario, clear priority: clear and a step in the same cycle at 12:34 -> 00:00 next cycle and terminal=0.
REQ-031 Scenario, scan and async reset: 5 scan_ticks at 12:34 -> index 1, digit_sel=4'b1101, bcd_out=3; reset pulsed between clk edges -> all outputs return to reset values immediately.
